// File: rtl/npc_sched_pkg.sv
// Shared types and constants for the next-PC scheduler.
// Holds FSM and redirect-kind encodings plus the PC alignment helper.
package npc_pkg;

    localparam int INST_ADDR_W = 32;

    typedef logic [INST_ADDR_W-1:0] addr_t;

    localparam addr_t FETCH_STRIDE_DEF = 32'd8;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef enum logic {
        RK_EXCP  = 1'b0,
        RK_FLUSH = 1'b1
    } rkind_t;

    function automatic addr_t align_pc(input addr_t a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/npc_sched_if.sv
// Redirect-request and fetch-PC bundle between the front end and npc_sched.
// The perf counters exist only when NPC_PERF_CNT_EN is defined.
interface npc_sched_if;
    import npc_pkg::*;

    logic [5:0] pause;
    logic       excp_en_i;
    addr_t      excp_pc_i;
    logic       flush_en_i;
    addr_t      flush_pc_i;
    logic       is_branch_i_1;
    logic       is_branch_i_2;
    logic       taken_or_not_1;
    logic       taken_or_not_2;
    addr_t      branch_target_addr_i_1;
    addr_t      branch_target_addr_i_2;
    addr_t      pc_o_1;
    addr_t      pc_o_2;
    logic       inst_en_o_1;
    logic       inst_en_o_2;
    logic       fetch_flush_o;
    logic       pending_o;
`ifdef NPC_PERF_CNT_EN
    logic [31:0] excp_cnt_o;
    logic [31:0] flush_cnt_o;
    logic [31:0] bpred_cnt_o;
`endif

    modport master (
`ifdef NPC_PERF_CNT_EN
        input  excp_cnt_o, flush_cnt_o, bpred_cnt_o,
`endif
        output pause, excp_en_i, excp_pc_i, flush_en_i, flush_pc_i,
        output is_branch_i_1, is_branch_i_2, taken_or_not_1, taken_or_not_2,
        output branch_target_addr_i_1, branch_target_addr_i_2,
        input  pc_o_1, pc_o_2, inst_en_o_1, inst_en_o_2, fetch_flush_o, pending_o
    );

    modport slave (
`ifdef NPC_PERF_CNT_EN
        output excp_cnt_o, flush_cnt_o, bpred_cnt_o,
`endif
        input  pause, excp_en_i, excp_pc_i, flush_en_i, flush_pc_i,
        input  is_branch_i_1, is_branch_i_2, taken_or_not_1, taken_or_not_2,
        input  branch_target_addr_i_1, branch_target_addr_i_2,
        output pc_o_1, pc_o_2, inst_en_o_1, inst_en_o_2, fetch_flush_o, pending_o
    );

endinterface

// File: rtl/npc_redirect_arb.sv
// Combinational fixed-priority next-PC select; zero latency, no backpressure.
// In replay mode the held redirect replaces flush/predictor sources, but a live exception still wins.
module npc_redirect_arb
    import npc_pkg::*;
#(
    parameter addr_t FETCH_STRIDE = FETCH_STRIDE_DEF
) (
    input  addr_t  cur_pc,
    input  logic   replay,
    input  addr_t  pend_pc,
    input  rkind_t pend_kind,
    input  logic   excp_en,
    input  addr_t  excp_pc,
    input  logic   flush_en,
    input  addr_t  flush_pc,
    input  logic   br_1,
    input  logic   tk_1,
    input  addr_t  tgt_1,
    input  logic   br_2,
    input  logic   tk_2,
    input  addr_t  tgt_2,
    output addr_t  next_pc,
    output logic   flush_kill,
    output rkind_t kind,
    output logic   bpred
);

    addr_t sel_pc;

    always_comb begin
        sel_pc     = cur_pc + FETCH_STRIDE;
        flush_kill = 1'b0;
        kind       = RK_EXCP;
        bpred      = 1'b0;
        if (excp_en) begin
            sel_pc     = excp_pc;
            flush_kill = 1'b1;
            kind       = RK_EXCP;
        end else if (replay) begin
            // A live flush only supersedes a held flush; a held exception is never displaced by it.
            flush_kill = 1'b1;
            kind       = pend_kind;
            sel_pc     = (flush_en && pend_kind == RK_FLUSH) ? flush_pc : pend_pc;
        end else if (flush_en) begin
            sel_pc     = flush_pc;
            flush_kill = 1'b1;
            kind       = RK_FLUSH;
        end else if (br_1 && tk_1) begin
            sel_pc = tgt_1;
            bpred  = 1'b1;
        end else if (br_2 && tk_2) begin
            sel_pc = tgt_2;
            bpred  = 1'b1;
        end
        next_pc = align_pc(sel_pc);
    end

endmodule

// File: rtl/npc_sched.sv
// Fetch-PC register and redirect FSM; a redirect lands on pc_o_1 one cycle after it is requested.
// pause[0] freezes the PC and parks exception/flush redirects in HOLD; NPC_PERF_CNT_EN adds redirect counters.
module npc_sched
    import npc_pkg::*;
#(
    parameter addr_t RESET_PC     = 32'h0000_0000,
    parameter addr_t FETCH_STRIDE = FETCH_STRIDE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    npc_sched_if.slave  bus
);

    state_t state_q, state_d;
    addr_t  pc_q, pc_d;
    logic   en_q, en_d;
    logic   fflush_q, fflush_d;
    logic   pend_q, pend_d;
    addr_t  ppc_q, ppc_d;
    rkind_t pkind_q, pkind_d;
    logic   apply;

    addr_t  arb_pc;
    logic   arb_kill;
    rkind_t arb_kind;
    logic   arb_bpred;

    logic stall;
    logic unused_pause;

    assign stall        = bus.pause[0];
    assign unused_pause = ^bus.pause[5:1];

    npc_redirect_arb #(.FETCH_STRIDE(FETCH_STRIDE)) u_arb (
        .cur_pc     (pc_q),
        .replay     (state_q == HOLD),
        .pend_pc    (ppc_q),
        .pend_kind  (pkind_q),
        .excp_en    (bus.excp_en_i),
        .excp_pc    (bus.excp_pc_i),
        .flush_en   (bus.flush_en_i),
        .flush_pc   (bus.flush_pc_i),
        .br_1       (bus.is_branch_i_1),
        .tk_1       (bus.taken_or_not_1),
        .tgt_1      (bus.branch_target_addr_i_1),
        .br_2       (bus.is_branch_i_2),
        .tk_2       (bus.taken_or_not_2),
        .tgt_2      (bus.branch_target_addr_i_2),
        .next_pc    (arb_pc),
        .flush_kill (arb_kill),
        .kind       (arb_kind),
        .bpred      (arb_bpred)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= BOOT;
            pc_q     <= RESET_PC;
            en_q     <= 1'b0;
            fflush_q <= 1'b0;
            pend_q   <= 1'b0;
            ppc_q    <= '0;
            pkind_q  <= RK_EXCP;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            en_q     <= en_d;
            fflush_q <= fflush_d;
            pend_q   <= pend_d;
            ppc_q    <= ppc_d;
            pkind_q  <= pkind_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        en_d     = en_q;
        fflush_d = 1'b0;
        pend_d   = pend_q;
        ppc_d    = ppc_q;
        pkind_d  = pkind_q;
        apply    = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                en_d    = 1'b1;
            end
            RUN: begin
                if (!stall) begin
                    pc_d     = arb_pc;
                    fflush_d = arb_kill;
                    apply    = 1'b1;
                end else if (bus.excp_en_i || bus.flush_en_i) begin
                    pend_d  = 1'b1;
                    ppc_d   = align_pc(bus.excp_en_i ? bus.excp_pc_i : bus.flush_pc_i);
                    pkind_d = bus.excp_en_i ? RK_EXCP : RK_FLUSH;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (!stall) begin
                    pc_d     = arb_pc;
                    fflush_d = arb_kill;
                    pend_d   = 1'b0;
                    apply    = 1'b1;
                    state_d  = RUN;
                end else if (bus.excp_en_i) begin
                    ppc_d   = align_pc(bus.excp_pc_i);
                    pkind_d = RK_EXCP;
                end else if (bus.flush_en_i && pkind_q == RK_FLUSH) begin
                    ppc_d = align_pc(bus.flush_pc_i);
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign bus.pc_o_1        = pc_q;
    assign bus.pc_o_2        = pc_q + 32'd4;
    assign bus.inst_en_o_1   = en_q;
    assign bus.inst_en_o_2   = en_q;
    assign bus.fetch_flush_o = fflush_q;
    assign bus.pending_o     = pend_q;

`ifdef NPC_PERF_CNT_EN
    logic [31:0] excp_cnt_q, flush_cnt_q, bpred_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            excp_cnt_q  <= '0;
            flush_cnt_q <= '0;
            bpred_cnt_q <= '0;
        end else if (apply) begin
            if (arb_kill && arb_kind == RK_EXCP)  excp_cnt_q  <= excp_cnt_q + 32'd1;
            if (arb_kill && arb_kind == RK_FLUSH) flush_cnt_q <= flush_cnt_q + 32'd1;
            if (arb_bpred)                        bpred_cnt_q <= bpred_cnt_q + 32'd1;
        end
    end

    assign bus.excp_cnt_o  = excp_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;
    assign bus.bpred_cnt_o = bpred_cnt_q;
`else
    logic unused_apply;
    assign unused_apply = apply ^ arb_bpred;
`endif

endmodule

// File: tb/tb_npc_sched.sv
// Directed bench for npc_sched: boot, priority, predictor slots, pause replay, wrap, async reset.
module tb_npc_sched;
    import npc_pkg::*;

    localparam addr_t RST_PC = 32'h1C00_0000;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    npc_sched_if bus ();

    npc_sched #(.RESET_PC(RST_PC)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.pause                  = 6'd0;
        bus.excp_en_i              = 1'b0;
        bus.excp_pc_i              = '0;
        bus.flush_en_i             = 1'b0;
        bus.flush_pc_i             = '0;
        bus.is_branch_i_1          = 1'b0;
        bus.is_branch_i_2          = 1'b0;
        bus.taken_or_not_1         = 1'b0;
        bus.taken_or_not_2         = 1'b0;
        bus.branch_target_addr_i_1 = '0;
        bus.branch_target_addr_i_2 = '0;
    endtask

    task automatic excp(input addr_t a);
        bus.excp_en_i = 1'b1;
        bus.excp_pc_i = a;
    endtask

    task automatic flush(input addr_t a);
        bus.flush_en_i = 1'b1;
        bus.flush_pc_i = a;
    endtask

    task automatic slot1(input logic tk, input addr_t a);
        bus.is_branch_i_1          = 1'b1;
        bus.taken_or_not_1         = tk;
        bus.branch_target_addr_i_1 = a;
    endtask

    task automatic slot2(input logic tk, input addr_t a);
        bus.is_branch_i_2          = 1'b1;
        bus.taken_or_not_2         = tk;
        bus.branch_target_addr_i_2 = a;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        clr();
        #2;
        chk("rst_pc1", bus.pc_o_1, RST_PC);
        chk("rst_pc2", bus.pc_o_2, RST_PC + 32'd4);
        chk("rst_en1", {31'd0, bus.inst_en_o_1}, 32'd0);
        chk("rst_en2", {31'd0, bus.inst_en_o_2}, 32'd0);
        chk("rst_ff", {31'd0, bus.fetch_flush_o}, 32'd0);
        chk("rst_pend", {31'd0, bus.pending_o}, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("boot_en_low", {31'd0, bus.inst_en_o_1}, 32'd0);
        tick();
        chk("boot_pc1", bus.pc_o_1, RST_PC);
        chk("boot_en1", {31'd0, bus.inst_en_o_1}, 32'd1);
        chk("boot_en2", {31'd0, bus.inst_en_o_2}, 32'd1);
        tick();
        chk("seq1_pc1", bus.pc_o_1, 32'h1C00_0008);
        chk("seq1_pc2", bus.pc_o_2, 32'h1C00_000C);
        tick();
        chk("seq2_pc1", bus.pc_o_1, 32'h1C00_0010);
        chk("seq2_pc2", bus.pc_o_2, 32'h1C00_0014);

        excp(32'h100); flush(32'h200); slot1(1'b1, 32'h300);
        tick();
        chk("prio_excp_pc", bus.pc_o_1, 32'h100);
        chk("prio_excp_pc2", bus.pc_o_2, 32'h104);
        chk("prio_excp_ff", {31'd0, bus.fetch_flush_o}, 32'd1);
        clr();
        tick();
        chk("prio_excp_seq", bus.pc_o_1, 32'h108);
        chk("prio_ff_drop", {31'd0, bus.fetch_flush_o}, 32'd0);
        flush(32'h200); slot1(1'b1, 32'h300);
        tick();
        chk("prio_flush_pc", bus.pc_o_1, 32'h200);
        chk("prio_flush_ff", {31'd0, bus.fetch_flush_o}, 32'd1);
        clr();
        tick();
        chk("prio_flush_seq", bus.pc_o_1, 32'h208);

        slot1(1'b1, 32'h40); slot2(1'b1, 32'h80);
        tick();
        chk("bp_s1_pc", bus.pc_o_1, 32'h40);
        chk("bp_s1_ff", {31'd0, bus.fetch_flush_o}, 32'd0);
        clr();
        slot1(1'b0, 32'h44); slot2(1'b1, 32'h82);
        tick();
        chk("bp_s2_pc", bus.pc_o_1, 32'h80);
        chk("bp_s2_ff", {31'd0, bus.fetch_flush_o}, 32'd0);
        clr();
        tick();
        chk("bp_seq", bus.pc_o_1, 32'h88);

        bus.pause = 6'd1; flush(32'h500);
        tick();
        chk("ps1_pc", bus.pc_o_1, 32'h88);
        chk("ps1_pend", {31'd0, bus.pending_o}, 32'd1);
        clr(); bus.pause = 6'd1; excp(32'h600);
        tick();
        chk("ps2_pc", bus.pc_o_1, 32'h88);
        chk("ps2_pend", {31'd0, bus.pending_o}, 32'd1);
        clr(); bus.pause = 6'd1; flush(32'h700);
        tick();
        chk("ps3_pc", bus.pc_o_1, 32'h88);
        clr(); bus.pause = 6'd1; slot1(1'b1, 32'h990);
        tick();
        chk("ps4_pc", bus.pc_o_1, 32'h88);
        chk("ps4_en", {31'd0, bus.inst_en_o_1}, 32'd1);
        chk("ps4_ff", {31'd0, bus.fetch_flush_o}, 32'd0);
        bus.pause = 6'd0; slot1(1'b1, 32'hAA0);
        tick();
        chk("rel_pc", bus.pc_o_1, 32'h600);
        chk("rel_ff", {31'd0, bus.fetch_flush_o}, 32'd1);
        chk("rel_pend", {31'd0, bus.pending_o}, 32'd0);
        clr();
        tick();
        chk("rel_seq", bus.pc_o_1, 32'h608);
        chk("rel_ff_once", {31'd0, bus.fetch_flush_o}, 32'd0);

        bus.pause = 6'd1; flush(32'h900);
        tick();
        flush(32'h940);
        tick();
        clr();
        tick();
        chk("fl_over_pc", bus.pc_o_1, 32'h940);
        bus.pause = 6'd1; excp(32'hB00);
        tick();
        clr(); flush(32'hC00);
        tick();
        chk("ex_keep_pc", bus.pc_o_1, 32'hB00);
        clr(); bus.pause = 6'd1; flush(32'hD00);
        tick();
        clr(); excp(32'hE00);
        tick();
        chk("live_excp_pc", bus.pc_o_1, 32'hE00);
        clr();

        excp(32'h0000_0123);
        tick();
        chk("align_pc", bus.pc_o_1, 32'h120);
        clr(); flush(32'hFFFF_FFF8);
        tick();
        chk("wrap_pre", bus.pc_o_1, 32'hFFFF_FFF8);
        chk("wrap_pre_pc2", bus.pc_o_2, 32'hFFFF_FFFC);
        clr();
        tick();
        chk("wrap_pc1", bus.pc_o_1, 32'h0);
        chk("wrap_pc2", bus.pc_o_2, 32'h4);
        flush(32'hFFFF_FFFC);
        tick();
        chk("wrap2_pc2", bus.pc_o_2, 32'h0);
        clr();

        bus.pause = 6'd1; excp(32'h700);
        tick();
        chk("arst_pend_pre", {31'd0, bus.pending_o}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_pc1", bus.pc_o_1, RST_PC);
        chk("arst_pc2", bus.pc_o_2, RST_PC + 32'd4);
        chk("arst_pend", {31'd0, bus.pending_o}, 32'd0);
        chk("arst_en", {31'd0, bus.inst_en_o_1}, 32'd0);
`ifdef NPC_PERF_CNT_EN
        chk("arst_cnt_e", bus.excp_cnt_o, 32'd0);
        chk("arst_cnt_f", bus.flush_cnt_o, 32'd0);
        chk("arst_cnt_b", bus.bpred_cnt_o, 32'd0);
`endif
        clr();
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("arst_boot_pc", bus.pc_o_1, RST_PC);
        chk("arst_boot_en", {31'd0, bus.inst_en_o_1}, 32'd1);
        tick();
        chk("arst_noreplay", bus.pc_o_1, RST_PC + 32'd8);
        chk("arst_ff", {31'd0, bus.fetch_flush_o}, 32'd0);

        excp(32'h1000);               tick(); clr();
        excp(32'h2000);               tick(); clr();
        flush(32'h3000);              tick(); clr();
        slot1(1'b1, 32'h4000);        tick(); clr();
        slot2(1'b1, 32'h5000);        tick(); clr();
        slot1(1'b1, 32'h6000);        tick(); clr();
        slot2(1'b1, 32'h7000);        tick(); clr();
        chk("perf_bp4_pc", bus.pc_o_1, 32'h7000);
        bus.pause = 6'd1; flush(32'h8000); tick(); clr();
        tick();
        chk("perf_replay_pc", bus.pc_o_1, 32'h8000);
        excp(32'h9000);               tick(); clr();
        slot1(1'b1, 32'hA000);        tick(); clr();
        tick();
        chk("perf_end_pc", bus.pc_o_1, 32'hA008);
`ifdef NPC_PERF_CNT_EN
        chk("cnt_excp", bus.excp_cnt_o, 32'd3);
        chk("cnt_flush", bus.flush_cnt_o, 32'd2);
        chk("cnt_bpred", bus.bpred_cnt_o, 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
